// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and parameter defaults for the SPI master
//
// Contents:
//   DATA_WIDTH_DEFAULT  default bits per SPI frame
//   CLK_DIV_DEFAULT     default clk cycles per SCLK half-period
//   spi_state_e         controller state encoding
//   divider_active()    states in which the SCLK half-period divider runs
package spi_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned CLK_DIV_DEFAULT    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    FINISH = 3'd3,
    HOLD   = 3'd4
  } spi_state_e;

  // The divider counts only while a timed phase is in progress; in IDLE and
  // FINISH it is held cleared so every timed phase starts from count zero.
  function automatic logic divider_active(input spi_state_e s);
    return (s == SETUP) || (s == SHIFT) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - SCLK half-period counter with rise/fall strobes
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en_i          count enable (SETUP, SHIFT, HOLD); counter clears when low
//   sclk_en_i     SCLK toggling phase active (SHIFT); phase clears when low
//   half_tick_o   last cycle of the current half-period
//   rise_tick_o   half-period end that raises SCLK
//   fall_tick_o   half-period end that lowers SCLK
module spi_sclk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sclk_en_i,
  output logic half_tick_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             half_end;

  always_comb begin
    half_end = en_i && (cnt_q == CNT_MAX);

    cnt_d = '0;
    if (en_i && !half_end) begin
      cnt_d = cnt_q + 1'b1;
    end

    // phase 0: SCLK low half (ends in a rise), phase 1: SCLK high half
    // (ends in a fall). Each SHIFT begins in the low half, which doubles as
    // MOSI setup time for back-to-back frames.
    phase_d = 1'b0;
    if (sclk_en_i) begin
      phase_d = half_end ? ~phase_q : phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign half_tick_o = half_end;
  assign rise_tick_o = half_end && sclk_en_i && !phase_q;
  assign fall_tick_o = half_end && sclk_en_i &&  phase_q;

endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - SPI mode 0 master between a TX FIFO and an RX FIFO
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   tx_data      TX FIFO head word (first-word fall-through)
//   tx_empty     TX FIFO empty flag
//   tx_rd_en     TX FIFO pop strobe (combinational)
//   rx_data      last received frame
//   rx_wr_en     RX FIFO push strobe, one cycle
//   rx_full      RX FIFO full flag
//   sclk         SPI clock, idles low
//   mosi         serial data out, MSB first
//   miso         serial data in, assumed synchronous to clk
//   cs_n         chip select, active low
//   busy         controller not in IDLE
//   rx_overflow  one-cycle pulse when a received frame is dropped
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_wr_en,
  input  logic                  rx_full,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  rx_overflow
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_wr_en_q, rx_wr_en_d;
  logic                  rx_ovf_q, rx_ovf_d;

  logic half_tick;
  logic rise_tick;
  logic fall_tick;
  logic pop;

  spi_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (divider_active(state_q)),
    .sclk_en_i   (state_q == SHIFT),
    .half_tick_o (half_tick),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // Words are only taken at frame boundaries; reset blocks the pop so a
  // held reset cannot drain the TX FIFO.
  assign pop = !rst && ((state_q == IDLE) || (state_q == FINISH)) && !tx_empty;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    rx_wr_en_d = 1'b0;
    rx_ovf_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_sh_d   = tx_data;
          mosi_d    = tx_data[DATA_WIDTH-1];
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (rise_tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
        end else if (fall_tick) begin
          sclk_d    = 1'b0;
          tx_sh_d   = tx_sh_q << 1;
          mosi_d    = tx_sh_q[DATA_WIDTH-2];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        if (!rx_full) begin
          rx_data_d  = rx_sh_q;
          rx_wr_en_d = 1'b1;
        end else begin
          rx_ovf_d = 1'b1;
        end
        if (pop) begin
          // Back-to-back: the leading low half of SHIFT covers MOSI setup.
          tx_sh_d   = tx_data;
          mosi_d    = tx_data[DATA_WIDTH-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (half_tick) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_wr_en_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_wr_en_q <= rx_wr_en_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  assign tx_rd_en    = pop;
  assign rx_data     = rx_data_q;
  assign rx_wr_en    = rx_wr_en_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign busy        = busy_q;
  assign rx_overflow = rx_ovf_q;

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - self-checking bench for spi_master_core
module tb_spi_master_core;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int SHIFT_CYC = 2 * DW * CD;
  localparam int CS_ONE = CD + SHIFT_CYC + 1 + CD;

  logic          clk;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_empty;
  logic          tx_rd_en;
  logic [DW-1:0] rx_data;
  logic          rx_wr_en;
  logic          rx_full;
  logic          sclk;
  logic          mosi;
  logic          miso_w;
  logic          cs_n;
  logic          busy;
  logic          rx_overflow;
  logic          loop_en;
  logic          miso_drv;

  int checks;
  int failures;

  spi_master_core #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_empty    (tx_empty),
    .tx_rd_en    (tx_rd_en),
    .rx_data     (rx_data),
    .rx_wr_en    (rx_wr_en),
    .rx_full     (rx_full),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso_w),
    .cs_n        (cs_n),
    .busy        (busy),
    .rx_overflow (rx_overflow)
  );

  assign miso_w = loop_en ? mosi : miso_drv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX FIFO model: pop seen mid-cycle takes effect just after the edge.
  logic [DW-1:0] txq[$];
  logic [DW-1:0] junk;
  bit            rd_seen;
  initial begin
    tx_empty = 1'b1;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      rd_seen = tx_rd_en;
      @(posedge clk);
      #1;
      if (rd_seen && txq.size() > 0) junk = txq.pop_front();
      tx_empty = (txq.size() == 0);
      tx_data  = (txq.size() > 0) ? txq[0] : '0;
    end
  end

  // Bus monitor plus a mode-0 slave that shifts out slq words on miso.
  logic [DW-1:0] slq[$];
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] mosiq[$];
  int  rise_cnt, rd_cnt, ovf_cnt, cs_frames, last_low, cs_run;
  int  sclk_tog, mosi_tog, cs_tog, mosi_hi;
  int  mnb, sl_nfall;
  logic [DW-1:0] mbits, sl_cur;
  bit  sl_active;
  logic prev_sclk, prev_mosi, prev_cs;
  initial begin
    miso_drv = 1'b0;
    sl_active = 0; mnb = 0; sl_nfall = 0; mbits = '0; sl_cur = '0;
    prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        mbits = {mbits[DW-2:0], mosi};
        mnb++;
        if (mnb == DW) begin
          mosiq.push_back(mbits);
          mnb = 0;
        end
      end
      if (!sclk && prev_sclk && sl_active) begin
        sl_nfall++;
        sl_cur = sl_cur << 1;
        if (sl_nfall == DW) begin
          sl_nfall = 0;
          if (slq.size() > 0) sl_cur = slq.pop_front();
        end
        miso_drv = sl_cur[DW-1];
      end
      if (!cs_n && !sl_active) begin
        sl_active = 1;
        sl_nfall  = 0;
        sl_cur    = (slq.size() > 0) ? slq.pop_front() : '0;
        miso_drv  = sl_cur[DW-1];
      end
      if (cs_n) begin
        sl_active = 0;
        mnb = 0;
      end
      if (tx_rd_en) rd_cnt++;
      if (rx_wr_en) rxq.push_back(rx_data);
      if (rx_overflow) ovf_cnt++;
      if (!cs_n) cs_run++;
      else if (!prev_cs) begin
        last_low = cs_run;
        cs_run = 0;
        cs_frames++;
      end
      if (sclk !== prev_sclk) sclk_tog++;
      if (mosi !== prev_mosi) mosi_tog++;
      if (cs_n !== prev_cs) cs_tog++;
      if (!cs_n && mosi) mosi_hi++;
      prev_sclk = sclk;
      prev_mosi = mosi;
      prev_cs   = cs_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic slot();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    rise_cnt = 0; rd_cnt = 0; ovf_cnt = 0; cs_frames = 0; last_low = 0; cs_run = 0;
    sclk_tog = 0; mosi_tog = 0; cs_tog = 0; mosi_hi = 0;
    rxq.delete(); mosiq.delete(); slq.delete();
  endtask

  // Wait for busy to rise and fall again; a timeout is a failed comparison.
  task automatic wait_done(input string name);
    bit started;
    bit ok;
    started = 0;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (busy) started = 1;
      else if (started) begin
        ok = 1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
    tick();
  endtask

  // MOSI high time for one frame: the MSB covers setup plus one full SCLK
  // period, every later bit one SCLK period.
  function automatic int exp_mosi_hi(input logic [DW-1:0] w);
    int c;
    c = w[DW-1] ? 3 * CD : 0;
    for (int i = 0; i < DW - 1; i++) if (w[i]) c += 2 * CD;
    return c;
  endfunction

  typedef struct {
    logic [DW-1:0] tx;
    bit            loop;
    logic [DW-1:0] sl;
    bit            full;
    logic [DW-1:0] exp_rx;
    int            exp_wr;
    int            exp_ovf;
  } vec_t;

  vec_t          vt[6];
  logic [DW-1:0] model_rx;
  logic [DW-1:0] tw[$];
  logic [DW-1:0] sw[$];
  int            nw;
  bit            rfull;
  int            rd_hold;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rx_full = 1'b0;
    loop_en = 1'b0;
    clr_mon();

    vt[0] = '{tx: 8'hA5, loop: 1, sl: 8'h00, full: 0, exp_rx: 8'hA5, exp_wr: 1, exp_ovf: 0};
    vt[1] = '{tx: 8'h80, loop: 0, sl: 8'h00, full: 0, exp_rx: 8'h00, exp_wr: 1, exp_ovf: 0};
    vt[2] = '{tx: 8'h5A, loop: 0, sl: 8'h3C, full: 0, exp_rx: 8'h3C, exp_wr: 1, exp_ovf: 0};
    vt[3] = '{tx: 8'h77, loop: 0, sl: 8'hFF, full: 1, exp_rx: 8'h3C, exp_wr: 0, exp_ovf: 1};
    vt[4] = '{tx: 8'hFF, loop: 1, sl: 8'h00, full: 0, exp_rx: 8'hFF, exp_wr: 1, exp_ovf: 0};
    vt[5] = '{tx: 8'h01, loop: 0, sl: 8'hC3, full: 0, exp_rx: 8'hC3, exp_wr: 1, exp_ovf: 0};

    // reset state
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_wr_en", 32'(rx_wr_en), 32'd0);
    check("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_rd_en", 32'(tx_rd_en), 32'd0);
    slot();
    rst = 1'b0;
    repeat (2) tick();

    // single-frame vector table
    for (int v = 0; v < 6; v++) begin
      slot();
      clr_mon();
      loop_en = vt[v].loop;
      rx_full = vt[v].full;
      slq.push_back(vt[v].sl);
      txq.push_back(vt[v].tx);
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_rx_data", v), 32'(rx_data), 32'(vt[v].exp_rx));
      check($sformatf("vec%0d_wr", v), 32'(rxq.size()), 32'(vt[v].exp_wr));
      if (rxq.size() > 0) check($sformatf("vec%0d_pushed", v), 32'(rxq[0]), 32'(vt[v].exp_rx));
      check($sformatf("vec%0d_ovf", v), 32'(ovf_cnt), 32'(vt[v].exp_ovf));
      check($sformatf("vec%0d_rises", v), 32'(rise_cnt), 32'(DW));
      check($sformatf("vec%0d_cs_low", v), 32'(last_low), 32'(CS_ONE));
      check($sformatf("vec%0d_rd", v), 32'(rd_cnt), 32'd1);
      check($sformatf("vec%0d_mosi_words", v), 32'(mosiq.size()), 32'd1);
      if (mosiq.size() > 0) check($sformatf("vec%0d_mosi", v), 32'(mosiq[0]), 32'(vt[v].tx));
      check($sformatf("vec%0d_mosi_hi", v), 32'(mosi_hi), 32'(exp_mosi_hi(vt[v].tx)));
    end
    model_rx = 8'hC3;

    // back-to-back frames
    slot();
    clr_mon();
    loop_en = 1'b1;
    rx_full = 1'b0;
    txq.push_back(8'h3C);
    txq.push_back(8'hC3);
    wait_done("b2b");
    check("b2b_cs_frames", 32'(cs_frames), 32'd1);
    check("b2b_cs_low", 32'(last_low), 32'(CD + 2 * (SHIFT_CYC + 1) + CD));
    check("b2b_rises", 32'(rise_cnt), 32'(2 * DW));
    check("b2b_rd", 32'(rd_cnt), 32'd2);
    check("b2b_wr", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      check("b2b_rx0", 32'(rxq[0]), 32'h3C);
      check("b2b_rx1", 32'(rxq[1]), 32'hC3);
    end
    model_rx = 8'hC3;

    // reset mid-frame after the 4th rise
    slot();
    clr_mon();
    loop_en = 1'b0;
    slq.push_back(8'h96);
    slq.push_back(8'h5A);
    txq.push_back(8'hE7);
    begin
      bit ok;
      ok = 0;
      for (int n = 0; n < 500; n++) begin
        tick();
        if (rise_cnt >= 4) begin
          ok = 1;
          break;
        end
      end
      check("abort_reach_rise4", 32'(ok), 32'd1);
    end
    slot();
    rst = 1'b1;
    tick();
    tick();
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    slot();
    txq.push_back(8'h1B);
    rd_hold = rd_cnt;
    repeat (6) tick();
    check("abort_tx_pending", 32'(tx_empty), 32'd0);
    check("abort_no_pop_in_rst", 32'(rd_cnt), 32'(rd_hold));
    check("abort_no_wr", 32'(rxq.size()), 32'd0);
    slot();
    rst = 1'b0;
    wait_done("after_abort");
    check("after_abort_wr", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("after_abort_rx", 32'(rxq[0]), 32'h5A);
    check("after_abort_mosi_words", 32'(mosiq.size()), 32'd1);
    if (mosiq.size() > 0) check("after_abort_mosi", 32'(mosiq[0]), 32'h1B);
    model_rx = 8'h5A;

    // idle bus
    slot();
    clr_mon();
    repeat (100) tick();
    check("idle_sclk_tog", 32'(sclk_tog), 32'd0);
    check("idle_mosi_tog", 32'(mosi_tog), 32'd0);
    check("idle_cs_tog", 32'(cs_tog), 32'd0);
    check("idle_rd", 32'(rd_cnt), 32'd0);

    // randomized bursts against the transaction-level model
    for (int it = 0; it < 20; it++) begin
      nw = $urandom_range(1, 3);
      rfull = 1'($urandom_range(0, 1));
      tw.delete();
      sw.delete();
      slot();
      clr_mon();
      loop_en = 1'b0;
      rx_full = rfull;
      for (int k = 0; k < nw; k++) begin
        tw.push_back(8'($urandom));
        sw.push_back(8'($urandom));
        slq.push_back(sw[k]);
        txq.push_back(tw[k]);
      end
      wait_done($sformatf("rnd%0d", it));
      if (!rfull) model_rx = sw[nw-1];
      check($sformatf("rnd%0d_rises", it), 32'(rise_cnt), 32'(nw * DW));
      check($sformatf("rnd%0d_rd", it), 32'(rd_cnt), 32'(nw));
      check($sformatf("rnd%0d_cs_frames", it), 32'(cs_frames), 32'd1);
      check($sformatf("rnd%0d_cs_low", it), 32'(last_low), 32'(CD + nw * (SHIFT_CYC + 1) + CD));
      check($sformatf("rnd%0d_wr", it), 32'(rxq.size()), rfull ? 32'd0 : 32'(nw));
      check($sformatf("rnd%0d_ovf", it), 32'(ovf_cnt), rfull ? 32'(nw) : 32'd0);
      check($sformatf("rnd%0d_rx_data", it), 32'(rx_data), 32'(model_rx));
      check($sformatf("rnd%0d_mosi_words", it), 32'(mosiq.size()), 32'(nw));
      for (int k = 0; k < nw; k++) begin
        if (k < mosiq.size()) check($sformatf("rnd%0d_mosi%0d", it, k), 32'(mosiq[k]), 32'(tw[k]));
        if (k < rxq.size()) check($sformatf("rnd%0d_rx%0d", it, k), 32'(rxq[k]), 32'(sw[k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
